regfile_nrd: RTL and testbench



---
 rtl/regfile_nrd.sv | 72 +++++++
 tb/tb_regfile_nrd.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_nrd.sv
// Multi-port register file: one synchronous write port, NUM_RD registered read ports with valid flags.
// Build option REGFILE_BYPASS_EN selects write-first on a same-edge read/write collision (read-first otherwise).
module regfile_nrd #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 4,
    parameter int NUM_RD = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        we,
    input  logic [$clog2(DEPTH)-1:0]    waddr,
    input  logic [WIDTH-1:0]            wdata,
    input  logic [NUM_RD-1:0]           re,
    input  logic [NUM_RD*$clog2(DEPTH)-1:0] raddr,
    output logic [NUM_RD*WIDTH-1:0]     rdata,
    output logic [NUM_RD-1:0]           rvalid
);
    localparam int ADDR_W = $clog2(DEPTH);
    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_ok;

    assign w_wr_ok = ({1'b0, waddr} < DEPTH_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we && w_wr_ok) begin
            r_mem[waddr] <= wdata;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_rd_ok;
        logic [WIDTH-1:0]  w_word;
        logic [WIDTH-1:0]  r_rdata;
        logic              r_rvalid;

        assign w_ra    = raddr[p*ADDR_W +: ADDR_W];
        assign w_rd_ok = ({1'b0, w_ra} < DEPTH_C);

`ifdef REGFILE_BYPASS_EN
        assign w_word = !w_rd_ok                          ? '0    :
                        (we && w_wr_ok && (waddr == w_ra)) ? wdata :
                                                             r_mem[w_ra];
`else
        assign w_word = w_rd_ok ? r_mem[w_ra] : '0;
`endif

        // Data holds when the port is idle; only the valid flag drops.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rdata  <= '0;
                r_rvalid <= 1'b0;
            end else begin
                r_rvalid <= re[p];
                if (re[p]) begin
                    r_rdata <= w_word;
                end
            end
        end

        assign rdata[p*WIDTH +: WIDTH] = r_rdata;
        assign rvalid[p]               = r_rvalid;
    end

endmodule

// File: tb/tb_regfile_nrd.sv
// Self-checking bench for regfile_nrd: directed table on a 4-entry build, out-of-range on a
// 5-entry build, and a randomized run on a 16x32, 3-port build against an array model.
module tb_regfile_nrd;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Instance A: 64 x 4, 2 ports
    logic         a_we;
    logic [1:0]   a_waddr;
    logic [63:0]  a_wdata;
    logic [1:0]   a_re;
    logic [3:0]   a_raddr;
    logic [127:0] a_rdata;
    logic [1:0]   a_rvalid;

    regfile_nrd #(.WIDTH(64), .DEPTH(4), .NUM_RD(2)) u_a (
        .clk(clk), .rst_n(rst_n), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
        .re(a_re), .raddr(a_raddr), .rdata(a_rdata), .rvalid(a_rvalid));

    // Instance B: 64 x 5, 2 ports (non power of two)
    logic         b_we;
    logic [2:0]   b_waddr;
    logic [63:0]  b_wdata;
    logic [1:0]   b_re;
    logic [5:0]   b_raddr;
    logic [127:0] b_rdata;
    logic [1:0]   b_rvalid;

    regfile_nrd #(.WIDTH(64), .DEPTH(5), .NUM_RD(2)) u_b (
        .clk(clk), .rst_n(rst_n), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
        .re(b_re), .raddr(b_raddr), .rdata(b_rdata), .rvalid(b_rvalid));

    // Instance C: 32 x 16, 3 ports
    logic         c_we;
    logic [3:0]   c_waddr;
    logic [31:0]  c_wdata;
    logic [2:0]   c_re;
    logic [11:0]  c_raddr;
    logic [95:0]  c_rdata;
    logic [2:0]   c_rvalid;

    regfile_nrd #(.WIDTH(32), .DEPTH(16), .NUM_RD(3)) u_c (
        .clk(clk), .rst_n(rst_n), .we(c_we), .waddr(c_waddr), .wdata(c_wdata),
        .re(c_re), .raddr(c_raddr), .rdata(c_rdata), .rvalid(c_rvalid));

    typedef struct {
        logic        we;
        logic [1:0]  waddr;
        logic [63:0] wdata;
        logic [1:0]  re;
        logic [1:0]  ra0;
        logic [1:0]  ra1;
        logic [1:0]  ev;
        logic [63:0] ed0;
        logic [63:0] ed1;
    } vec_t;

    localparam logic [63:0] DB = 64'hDEAD_BEEF_0000_0001;

    task automatic b_cyc(input logic we, input logic [2:0] wa, input logic [63:0] wd,
                         input logic [1:0] re, input logic [2:0] r0, input logic [2:0] r1);
        b_we = we; b_waddr = wa; b_wdata = wd; b_re = re; b_raddr = {r1, r0};
        @(posedge clk); #1;
    endtask

    task automatic b_chk(input string nm, input logic [1:0] ev, input logic [63:0] e0,
                         input logic [63:0] e1);
        chk({nm, " rvalid"}, 64'(b_rvalid), 64'(ev));
        chk({nm, " d0"}, b_rdata[63:0], e0);
        chk({nm, " d1"}, b_rdata[127:64], e1);
    endtask

    vec_t tbl[12];
    logic [31:0] m_mem [16];
    logic [31:0] m_d   [3];
    logic        m_v   [3];
    logic [3:0]  ra    [3];

    initial begin
        tbl[0]  = '{1'b1, 2'd2, DB,       2'b00, 2'd0, 2'd0, 2'b00, 64'h0,  64'h0};
        tbl[1]  = '{1'b0, 2'd0, 64'h0,    2'b01, 2'd2, 2'd0, 2'b01, DB,     64'h0};
        tbl[2]  = '{1'b1, 2'd3, 64'h33,   2'b00, 2'd0, 2'd0, 2'b00, DB,     64'h0};
        tbl[3]  = '{1'b0, 2'd0, 64'h0,    2'b11, 2'd3, 2'd3, 2'b11, 64'h33, 64'h33};
        tbl[4]  = '{1'b0, 2'd0, 64'h0,    2'b00, 2'd3, 2'd3, 2'b00, 64'h33, 64'h33};
        tbl[5]  = '{1'b1, 2'd1, 64'hA,    2'b01, 2'd0, 2'd0, 2'b01, 64'h0,  64'h33};
        tbl[6]  = '{1'b1, 2'd1, 64'hB,    2'b10, 2'd0, 2'd1, 2'b10, 64'h0,  BYP ? 64'hB : 64'hA};
        tbl[7]  = '{1'b0, 2'd0, 64'h0,    2'b10, 2'd0, 2'd1, 2'b10, 64'h0,  64'hB};
        tbl[8]  = '{1'b1, 2'd0, 64'h55,   2'b11, 2'd2, 2'd0, 2'b11, DB,     BYP ? 64'h55 : 64'h0};
        tbl[9]  = '{1'b0, 2'd0, 64'h0,    2'b11, 2'd0, 2'd3, 2'b11, 64'h55, 64'h33};
        tbl[10] = '{1'b0, 2'd2, 64'hFFFF, 2'b00, 2'd0, 2'd0, 2'b00, 64'h55, 64'h33};
        tbl[11] = '{1'b0, 2'd0, 64'h0,    2'b01, 2'd2, 2'd0, 2'b01, DB,     64'h33};

        a_we = 0; a_waddr = 0; a_wdata = 0; a_re = 0; a_raddr = 0;
        b_we = 0; b_waddr = 0; b_wdata = 0; b_re = 0; b_raddr = 0;
        c_we = 0; c_waddr = 0; c_wdata = 0; c_re = 0; c_raddr = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset A rvalid", 64'(a_rvalid), 64'h0);
        chk("reset A rdata lo", a_rdata[63:0], 64'h0);
        chk("reset C rvalid", 64'(c_rvalid), 64'h0);
        rst_n = 1'b1;

        // Directed table on instance A
        for (int i = 0; i < 12; i++) begin
            a_we = tbl[i].we; a_waddr = tbl[i].waddr; a_wdata = tbl[i].wdata;
            a_re = tbl[i].re; a_raddr = {tbl[i].ra1, tbl[i].ra0};
            @(posedge clk); #1;
            chk($sformatf("tbl[%0d] rvalid", i), 64'(a_rvalid), 64'(tbl[i].ev));
            chk($sformatf("tbl[%0d] d0", i), a_rdata[63:0], tbl[i].ed0);
            chk($sformatf("tbl[%0d] d1", i), a_rdata[127:64], tbl[i].ed1);
        end

        // Reset in the middle of back-to-back reads
        a_we = 0; a_re = 2'b11; a_raddr = {2'd3, 2'd2};
        @(posedge clk); #1;
        chk("pre-rst rvalid", 64'(a_rvalid), 64'h3);
        chk("pre-rst d0", a_rdata[63:0], DB);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst rvalid", 64'(a_rvalid), 64'h0);
        chk("async rst d0", a_rdata[63:0], 64'h0);
        chk("async rst d1", a_rdata[127:64], 64'h0);
        @(posedge clk); #1;
        chk("in rst rvalid", 64'(a_rvalid), 64'h0);
        rst_n = 1'b1;
        a_raddr = {2'd1, 2'd0};
        @(posedge clk); #1;
        chk("post-rst rvalid", 64'(a_rvalid), 64'h3);
        chk("post-rst e0", a_rdata[63:0], 64'h0);
        chk("post-rst e1", a_rdata[127:64], 64'h0);
        a_raddr = {2'd3, 2'd2};
        @(posedge clk); #1;
        chk("post-rst e2", a_rdata[63:0], 64'h0);
        chk("post-rst e3", a_rdata[127:64], 64'h0);
        a_re = 2'b00;

        // Out-of-range handling on instance B
        b_cyc(1'b1, 3'd4, 64'h44, 2'b00, 3'd0, 3'd0);
        b_cyc(1'b1, 3'd6, 64'hF,  2'b00, 3'd0, 3'd0);
        b_cyc(1'b1, 3'd5, 64'hE,  2'b00, 3'd0, 3'd0);
        b_cyc(1'b0, 3'd0, 64'h0,  2'b11, 3'd4, 3'd7);
        b_chk("B rd4/7", 2'b11, 64'h44, 64'h0);
        b_cyc(1'b0, 3'd0, 64'h0,  2'b01, 3'd7, 3'd0);
        b_chk("B rd7 after 4", 2'b01, 64'h0, 64'h0);
        b_cyc(1'b1, 3'd6, 64'hF,  2'b11, 3'd6, 3'd5);
        b_chk("B oor collide", 2'b11, 64'h0, 64'h0);
        b_cyc(1'b0, 3'd0, 64'h0,  2'b11, 3'd0, 3'd1);
        b_chk("B e0/e1", 2'b11, 64'h0, 64'h0);
        b_cyc(1'b0, 3'd0, 64'h0,  2'b11, 3'd2, 3'd3);
        b_chk("B e2/e3", 2'b11, 64'h0, 64'h0);
        b_cyc(1'b0, 3'd0, 64'h0,  2'b11, 3'd4, 3'd4);
        b_chk("B e4", 2'b11, 64'h44, 64'h44);
        b_re = 2'b00;

        // Randomized run on instance C (storage and outputs still at reset values)
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        for (int p = 0; p < 3; p++) begin m_d[p] = '0; m_v[p] = 1'b0; end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            c_we    = 1'($urandom_range(0, 1));
            c_waddr = 4'($urandom_range(0, 15));
            c_wdata = $urandom;
            c_re    = 3'($urandom_range(0, 7));
            for (int p = 0; p < 3; p++) begin
                ra[p] = ($urandom_range(0, 3) == 0) ? c_waddr : 4'($urandom_range(0, 15));
                c_raddr[p*4 +: 4] = ra[p];
                m_v[p] = c_re[p];
                if (c_re[p]) begin
                    m_d[p] = (BYP && c_we && (c_waddr == ra[p])) ? c_wdata : m_mem[ra[p]];
                end
            end
            if (c_we) m_mem[c_waddr] = c_wdata;
            @(posedge clk); #1;
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("rand c%0d p%0d rvalid", cyc, p), 64'(c_rvalid[p]), 64'(m_v[p]));
                chk($sformatf("rand c%0d p%0d data", cyc, p), 64'(c_rdata[p*32 +: 32]), 64'(m_d[p]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
